// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared state encoding, datapath width and id sizing for adder schedulers
package adder_sched_pkg;
    localparam int DATA_W = 64;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
    function automatic int id_width(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/rca64.sv
// rca64: 64-bit ripple-carry adder, carry propagated bit by bit
module rca64 import adder_sched_pkg::*; (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);
    logic c;
    always_comb begin
        c = cin;
        sum = '0;
        for (int i = 0; i < DATA_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr
module rr_arbiter import adder_sched_pkg::*; #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]               req,
    input  logic [id_width(NUM_REQ)-1:0]     ptr,
    output logic [NUM_REQ-1:0]               grant,
    output logic [id_width(NUM_REQ)-1:0]     idx,
    output logic                             any
);
    localparam int IW = id_width(NUM_REQ);
    logic [IW-1:0] j;
    assign any = |req;
    // Scan from the farthest offset down so the nearest set bit after ptr wins.
    always_comb begin
        j = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IW'((32'(ptr) + 32'(k)) % NUM_REQ);
            if (req[j]) idx = j;
        end
        grant = any ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/adder_rr_sched.sv
// adder_rr_sched: one shared 64-bit ripple adder time-multiplexed among round-robin requesters
// Optional ADDER_SCHED_OVF_EN adds the out_ovf signed-overflow result port.
module adder_rr_sched import adder_sched_pkg::*; #(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_a,
    input  logic [NUM_REQ*DATA_W-1:0]     req_b,
    input  logic [NUM_REQ-1:0]            req_cin,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_sum,
    output logic                          out_cout,
    output logic [id_width(NUM_REQ)-1:0]  out_id,
`ifdef ADDER_SCHED_OVF_EN
    output logic                          out_ovf,
`endif
    output logic                          busy
);
    localparam int IW = id_width(NUM_REQ);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d, gnt_idx;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt;
    logic                gnt_any, cin_q, cout_w, accept, capture;
    logic [DATA_W-1:0]   a_q, b_q, sum_w;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(req_valid), .ptr(ptr_q), .grant(gnt), .idx(gnt_idx), .any(gnt_any)
    );
    rca64 u_rca (.a(a_q), .b(b_q), .cin(cin_q), .sum(sum_w), .cout(cout_w));
    assign accept    = state_q == IDLE && gnt_any;
    assign capture   = state_q == BUSY && cnt_q == '0;
    assign req_ready = accept ? gnt : '0;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (gnt_any) begin
                state_d = BUSY;
                ptr_d = gnt_idx == IW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                cnt_d = CW'(SETTLE_CYCLES - 1);
            end
            BUSY: if (capture) state_d = DONE; else cnt_d = cnt_q - 1'b1;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            out_id   <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
`ifdef ADDER_SCHED_OVF_EN
            out_ovf  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_q    <= req_a[DATA_W*gnt_idx +: DATA_W];
                b_q    <= req_b[DATA_W*gnt_idx +: DATA_W];
                cin_q  <= req_cin[gnt_idx];
                out_id <= gnt_idx;
            end
            // Operands have been stable for SETTLE_CYCLES, so the ripple has resolved.
            if (capture) begin
                out_sum  <= sum_w;
                out_cout <= cout_w;
`ifdef ADDER_SCHED_OVF_EN
                out_ovf  <= (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum_w[DATA_W-1] != a_q[DATA_W-1]);
`endif
            end
        end
    end
endmodule

// File: tb/tb_adder_rr_sched.sv
// tb_adder_rr_sched: directed self-checking bench for adder_rr_sched (NUM_REQ=4, SETTLE_CYCLES=2)
module tb_adder_rr_sched;
    localparam int N = 4;
    localparam int S = 2;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*64-1:0] req_a = '0;
    logic [N*64-1:0] req_b = '0;
    logic [N-1:0]  req_cin = '0;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_sum;
    logic          out_cout;
    logic [1:0]    out_id;
    logic          busy;
`ifdef ADDER_SCHED_OVF_EN
    logic          out_ovf;
`endif
    int errors = 0;
    int checks = 0;

    adder_rr_sched #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_cin(req_cin), .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_id(out_id),
`ifdef ADDER_SCHED_OVF_EN
        .out_ovf(out_ovf),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_sum !== 64'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0", out_sum); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", out_id); end
        rst_n = 1'b1;
        req_valid = 4'b0100;
        req_a[128 +: 64] = 64'h1234;
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got=%b exp=1", busy); end
        req_valid = '0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid got=%b exp=0", out_valid); end
        for (int c = 0; c < S + 3; c++) begin
            tick;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_dropped cyc=%0d got=%b exp=0", c, out_valid); end
        end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_ptr got=%b exp=0001", req_ready); end
        req_valid = '0;
        req_a = '0;
    endtask

    task automatic test_fairness;
        int n = 0;
        int last = 0;
        logic [N-1:0] exp;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 200 && n < 5; c++) begin
            if (req_ready !== 4'b0000) begin
                exp = 4'b0001 << (n % N);
                checks++; if (req_ready !== exp) begin errors++; $display("FAIL fair_grant n=%0d got=%b exp=%b", n, req_ready, exp); end
                if (n > 0) begin
                    checks++; if (c - last !== S + 2) begin errors++; $display("FAIL fair_gap n=%0d got=%0d exp=%0d", n, c - last, S + 2); end
                end
                last = c;
                n++;
            end
            tick;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL fair_timeout grants=%0d exp=5", n); end
        req_valid = '0;
        for (int c = 0; c < 20 && busy !== 1'b0; c++) tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_drain busy=%b exp=0", busy); end
        out_ready = 1'b0;
    endtask

    task automatic test_single;
        req_valid = 4'b0100;
        req_a[128 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
        req_b[128 +: 64] = 64'h1;
        req_cin = '0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
        tick;
        req_valid = '0;
        req_a[128 +: 64] = 64'h5555;
        for (int c = 1; c <= S; c++) begin
            tick;
            checks++; if (out_valid !== (c == S)) begin errors++; $display("FAIL single_latency cyc=%0d got=%b exp=%b", c, out_valid, c == S); end
        end
        checks++; if (out_sum !== 64'h0) begin errors++; $display("FAIL single_sum got=%h exp=0", out_sum); end
        checks++; if (out_cout !== 1'b1) begin errors++; $display("FAIL single_cout got=%b exp=1", out_cout); end
        checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL single_id got=%0d exp=2", out_id); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_release got=%b exp=0", out_valid); end
    endtask

    task automatic test_wrap;
        req_valid = 4'b0010;
        req_a[64 +: 64] = 64'h8000_0000_0000_0000;
        req_b[64 +: 64] = 64'h8000_0000_0000_0000;
        req_cin = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant got=%b exp=0010", req_ready); end
        tick;
        req_valid = '0;
        repeat (S) tick;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b exp=1", out_valid); end
        checks++; if (out_sum !== 64'h1) begin errors++; $display("FAIL wrap_sum got=%h exp=1", out_sum); end
        checks++; if (out_cout !== 1'b1) begin errors++; $display("FAIL wrap_cout got=%b exp=1", out_cout); end
        checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL wrap_id got=%0d exp=1", out_id); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        req_valid = 4'b1111;
        req_a[128 +: 64] = 64'h5;
        req_b[128 +: 64] = 64'h7;
        req_cin = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_ptr_after_wrap got=%b exp=0100", req_ready); end
        tick;
        repeat (S) tick;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
        for (int c = 0; c < 10; c++) begin
            tick;
            checks++; if (out_valid !== 1'b1 || out_sum !== 64'hD || out_id !== 2'd2)
                begin errors++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d exp=1/d/2", c, out_valid, out_sum, out_id); end
            checks++; if (req_ready !== 4'b0000 || busy !== 1'b1)
                begin errors++; $display("FAIL bp_stall cyc=%0d ready=%b busy=%b exp=0000/1", c, req_ready, busy); end
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release valid=%b busy=%b exp=0/0", out_valid, busy); end
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant got=%b exp=1000", req_ready); end
        req_valid = '0;
        req_cin = '0;
    endtask

`ifdef ADDER_SCHED_OVF_EN
    task automatic test_ovf;
        req_valid = 4'b1000;
        req_a[192 +: 64] = 64'h7FFF_FFFF_FFFF_FFFF;
        req_b[192 +: 64] = 64'h1;
        tick;
        req_valid = '0;
        repeat (S) tick;
        checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", out_ovf); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL ovf_cout got=%b exp=0", out_cout); end
        checks++; if (out_sum !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_sum got=%h exp=8000000000000000", out_sum); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_fairness;
        test_single;
        test_wrap;
        test_backpressure;
`ifdef ADDER_SCHED_OVF_EN
        test_ovf;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
